// File: rtl/bank_xbar_rr.sv
// Read crossbar: NUM_RD_PORTS CPU ports onto NUM_BANKS SRAM banks, round-robin per bank.
// Optional word-interleaved bank mapping is enabled by defining XBAR_INTERLEAVE_EN.
module bank_xbar_rr #(
    parameter int NUM_BANKS          = 3,
    parameter int SIZE_BANKI         = 32,
    parameter int NUM_RD_PORTS       = 8,
    parameter int DATA_W             = 32,
    parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
    parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS)
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NUM_RD_PORTS-1:0]                         req_cpu,
    input  logic [NUM_RD_PORTS-1:0][SHIRINA_VSEH_BANOK-1:0] adr_cpu,
    output logic [NUM_RD_PORTS-1:0]                         gnt_cpu,
    output logic [NUM_RD_PORTS-1:0]                         rd_valid_cpu,
    output logic [NUM_RD_PORTS-1:0]                         rd_err_cpu,
    output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]             rd_cpu,
    output logic [NUM_BANKS-1:0]                            en_banki,
    output logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]         adr_banki,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]                rd_banki
);

    localparam int PW    = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
    localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int LIMIT = NUM_BANKS * SIZE_BANKI;
    localparam logic [PW-1:0] LAST = PW'(NUM_RD_PORTS - 1);

    logic [NUM_RD_PORTS-1:0][BW-1:0]            bank_sel;
    logic [NUM_RD_PORTS-1:0][SHIRINA_BANKI-1:0] offset;
    logic [NUM_RD_PORTS-1:0]                    oor;

    logic [NUM_BANKS-1:0][PW-1:0] rr_ptr;
    logic [NUM_BANKS-1:0][PW-1:0] win;
    logic [NUM_BANKS-1:0]         win_v;
    logic [PW-1:0]                pi;

    logic [NUM_BANKS-1:0]          route_v;
    logic [NUM_BANKS-1:0][PW-1:0]  route_p;
    logic [NUM_RD_PORTS-1:0]       oor_pend;

    // Address decode: target bank, bank-local offset and out-of-range flag per port
    always_comb begin
        bank_sel = '0;
        offset   = '0;
        oor      = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            oor[p] = 32'(adr_cpu[p]) >= 32'(LIMIT);
`ifdef XBAR_INTERLEAVE_EN
            bank_sel[p] = BW'(adr_cpu[p] % SHIRINA_VSEH_BANOK'(NUM_BANKS));
            offset[p]   = SHIRINA_BANKI'(adr_cpu[p] / SHIRINA_VSEH_BANOK'(NUM_BANKS));
`else
            bank_sel[p] = BW'(adr_cpu[p] >> SHIRINA_BANKI);
            offset[p]   = adr_cpu[p][SHIRINA_BANKI-1:0];
`endif
        end
    end

    // Per-bank round-robin search starting at rr_ptr; OOR requests never compete
    always_comb begin
        win   = '0;
        win_v = '0;
        pi    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_RD_PORTS; k++) begin
                pi = PW'((int'(rr_ptr[b]) + k) % NUM_RD_PORTS);
                if (!win_v[b] && req_cpu[pi] && !oor[pi] &&
                    bank_sel[pi] == BW'(b)) begin
                    win_v[b] = 1'b1;
                    win[b]   = pi;
                end
            end
        end
    end

    // Grants and bank drive; everything held quiet while reset is asserted
    always_comb begin
        gnt_cpu   = req_cpu & oor;
        en_banki  = '0;
        adr_banki = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (win_v[b]) begin
                gnt_cpu[win[b]] = 1'b1;
                en_banki[b]     = 1'b1;
                adr_banki[b]    = offset[win[b]];
            end
        end
        if (!rst_n) begin
            gnt_cpu   = '0;
            en_banki  = '0;
            adr_banki = '0;
        end
    end

    // Pointer advance past each winner, and return-route capture for next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            route_v  <= '0;
            route_p  <= '0;
            oor_pend <= '0;
        end else begin
            oor_pend <= req_cpu & oor;
            for (int b = 0; b < NUM_BANKS; b++) begin
                route_v[b] <= win_v[b];
                if (win_v[b]) begin
                    route_p[b] <= win[b];
                    rr_ptr[b]  <= (win[b] == LAST) ? '0 : win[b] + 1'b1;
                end
            end
        end
    end

    // Return path: steer bank data to the port recorded in each route entry
    always_comb begin
        rd_valid_cpu = oor_pend;
        rd_err_cpu   = oor_pend;
        rd_cpu       = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (route_v[b]) begin
                rd_valid_cpu[route_p[b]] = 1'b1;
                rd_cpu[route_p[b]]       = rd_banki[b];
            end
        end
    end

endmodule

// File: tb/tb_bank_xbar_rr.sv
// Directed bench for bank_xbar_rr with default parameters.
// Bank SRAMs are modelled as a fixed data pattern returned one cycle after enable.
module tb_bank_xbar_rr;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           req_cpu;
    logic [7:0][6:0]      adr_cpu;
    logic [7:0]           gnt_cpu;
    logic [7:0]           rd_valid_cpu;
    logic [7:0]           rd_err_cpu;
    logic [7:0][31:0]     rd_cpu;
    logic [2:0]           en_banki;
    logic [2:0][4:0]      adr_banki;
    logic [2:0][31:0]     rd_banki;

    int tests = 0;
    int fails = 0;

    bank_xbar_rr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_cpu      (req_cpu),
        .adr_cpu      (adr_cpu),
        .gnt_cpu      (gnt_cpu),
        .rd_valid_cpu (rd_valid_cpu),
        .rd_err_cpu   (rd_err_cpu),
        .rd_cpu       (rd_cpu),
        .en_banki     (en_banki),
        .adr_banki    (adr_banki),
        .rd_banki     (rd_banki)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(int b, int off);
        return 32'hA500_0000 + 32'(b * 256 + off);
    endfunction

    // Synchronous bank model
    always @(posedge clk) begin
        for (int b = 0; b < 3; b++)
            rd_banki[b] <= en_banki[b] ? mem_word(b, int'(adr_banki[b])) : 32'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_cpu = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req_cpu = 8'hFF;
        adr_cpu = '0;
        tick();
        tick();
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h00) begin fails++; $display("FAIL reset_gnt got %b want 0", gnt_cpu); end
        tests++; if (en_banki !== 3'b000) begin fails++; $display("FAIL reset_en got %b want 0", en_banki); end
        tests++; if (rd_valid_cpu !== 8'h00) begin fails++; $display("FAIL reset_valid got %b want 0", rd_valid_cpu); end
        tests++; if (rd_err_cpu !== 8'h00) begin fails++; $display("FAIL reset_err got %b want 0", rd_err_cpu); end
        tests++; if (rd_cpu !== '0) begin fails++; $display("FAIL reset_rd got %h want 0", rd_cpu); end
        req_cpu = '0;
        rst_n   = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_cpu    = 8'h04;
        adr_cpu[2] = 7'd37;
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h04) begin fails++; $display("FAIL single_gnt got %b want 00000100", gnt_cpu); end
        tests++; if (en_banki !== 3'b010) begin fails++; $display("FAIL single_en got %b want 010", en_banki); end
        tests++; if (adr_banki[1] !== 5'd5) begin fails++; $display("FAIL single_adr got %0d want 5", adr_banki[1]); end
        tick();
        req_cpu = '0;
        tests++; if (rd_valid_cpu !== 8'h04) begin fails++; $display("FAIL single_valid got %b want 00000100", rd_valid_cpu); end
        tests++; if (rd_err_cpu !== 8'h00) begin fails++; $display("FAIL single_err got %b want 0", rd_err_cpu); end
        tests++; if (rd_cpu[2] !== mem_word(1, 5)) begin fails++; $display("FAIL single_data got %h want %h", rd_cpu[2], mem_word(1, 5)); end
        tests++; if (rd_cpu[0] !== 32'h0) begin fails++; $display("FAIL single_idle_data got %h want 0", rd_cpu[0]); end
        tick();
        tests++; if (rd_valid_cpu !== 8'h00) begin fails++; $display("FAIL single_after got %b want 0", rd_valid_cpu); end
    endtask

    task automatic test_conflict();
        int ord[4] = '{0, 3, 7, 0};
        int offs[8] = '{1, 0, 0, 2, 0, 0, 0, 3};
        int w;
        int pv;
        do_reset();
        req_cpu    = 8'b1000_1001;
        adr_cpu[0] = 7'd1;
        adr_cpu[3] = 7'd2;
        adr_cpu[7] = 7'd3;
        for (int i = 0; i < 4; i++) begin
            w = ord[i];
            @(negedge clk);
            tests++; if (gnt_cpu !== 8'(1 << w)) begin fails++; $display("FAIL conflict_gnt%0d got %b want port %0d", i, gnt_cpu, w); end
            tests++; if (adr_banki[0] !== 5'(offs[w])) begin fails++; $display("FAIL conflict_adr%0d got %0d want %0d", i, adr_banki[0], offs[w]); end
            if (i > 0) begin
                pv = ord[i-1];
                tests++; if (rd_valid_cpu !== 8'(1 << pv)) begin fails++; $display("FAIL conflict_valid%0d got %b want port %0d", i, rd_valid_cpu, pv); end
                tests++; if (rd_cpu[pv] !== mem_word(0, offs[pv])) begin fails++; $display("FAIL conflict_data%0d got %h want %h", i, rd_cpu[pv], mem_word(0, offs[pv])); end
            end
            tick();
        end
        req_cpu = '0;
        @(negedge clk);
        tests++; if (rd_valid_cpu !== 8'h01) begin fails++; $display("FAIL conflict_last_valid got %b want 00000001", rd_valid_cpu); end
        tests++; if (rd_cpu[0] !== mem_word(0, 1)) begin fails++; $display("FAIL conflict_last_data got %h want %h", rd_cpu[0], mem_word(0, 1)); end
        tests++; if (gnt_cpu !== 8'h00) begin fails++; $display("FAIL conflict_idle_gnt got %b want 0", gnt_cpu); end
        tick();
    endtask

    task automatic test_parallel();
        req_cpu    = 8'b0011_0010;
        adr_cpu[1] = 7'd3;
        adr_cpu[4] = 7'd40;
        adr_cpu[5] = 7'd70;
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h32) begin fails++; $display("FAIL par_gnt got %b want 00110010", gnt_cpu); end
        tests++; if (en_banki !== 3'b111) begin fails++; $display("FAIL par_en got %b want 111", en_banki); end
        tests++; if (adr_banki !== {5'd6, 5'd8, 5'd3}) begin fails++; $display("FAIL par_adr got %h want %h", adr_banki, {5'd6, 5'd8, 5'd3}); end
        tick();
        req_cpu = '0;
        tests++; if (rd_valid_cpu !== 8'h32) begin fails++; $display("FAIL par_valid got %b want 00110010", rd_valid_cpu); end
        tests++; if (rd_cpu[1] !== mem_word(0, 3)) begin fails++; $display("FAIL par_data1 got %h want %h", rd_cpu[1], mem_word(0, 3)); end
        tests++; if (rd_cpu[4] !== mem_word(1, 8)) begin fails++; $display("FAIL par_data4 got %h want %h", rd_cpu[4], mem_word(1, 8)); end
        tests++; if (rd_cpu[5] !== mem_word(2, 6)) begin fails++; $display("FAIL par_data5 got %h want %h", rd_cpu[5], mem_word(2, 6)); end
        tick();
    endtask

    task automatic test_oor();
        req_cpu    = 8'h40;
        adr_cpu[6] = 7'd100;
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h40) begin fails++; $display("FAIL oor_gnt got %b want 01000000", gnt_cpu); end
        tests++; if (en_banki !== 3'b000) begin fails++; $display("FAIL oor_en got %b want 000", en_banki); end
        tick();
        req_cpu = '0;
        tests++; if (rd_valid_cpu !== 8'h40) begin fails++; $display("FAIL oor_valid got %b want 01000000", rd_valid_cpu); end
        tests++; if (rd_err_cpu !== 8'h40) begin fails++; $display("FAIL oor_err got %b want 01000000", rd_err_cpu); end
        tests++; if (rd_cpu[6] !== 32'h0) begin fails++; $display("FAIL oor_data got %h want 0", rd_cpu[6]); end
        req_cpu    = 8'h03;
        adr_cpu[0] = 7'd95;
        adr_cpu[1] = 7'd96;
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h03) begin fails++; $display("FAIL edge_gnt got %b want 00000011", gnt_cpu); end
        tests++; if (en_banki !== 3'b100) begin fails++; $display("FAIL edge_en got %b want 100", en_banki); end
        tests++; if (adr_banki[2] !== 5'd31) begin fails++; $display("FAIL edge_adr got %0d want 31", adr_banki[2]); end
        tick();
        req_cpu = '0;
        tests++; if (rd_valid_cpu !== 8'h03) begin fails++; $display("FAIL edge_valid got %b want 00000011", rd_valid_cpu); end
        tests++; if (rd_err_cpu !== 8'h02) begin fails++; $display("FAIL edge_err got %b want 00000010", rd_err_cpu); end
        tests++; if (rd_cpu[0] !== mem_word(2, 31)) begin fails++; $display("FAIL edge_data got %h want %h", rd_cpu[0], mem_word(2, 31)); end
        tests++; if (rd_cpu[1] !== 32'h0) begin fails++; $display("FAIL edge_errdata got %h want 0", rd_cpu[1]); end
        tick();
    endtask

    task automatic test_reset_mid();
        req_cpu    = 8'h04;
        adr_cpu[2] = 7'd37;
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h04) begin fails++; $display("FAIL mid_gnt got %b want 00000100", gnt_cpu); end
        tick();
        req_cpu = '0;
        rst_n   = 1'b0;
        #1;
        tests++; if (rd_valid_cpu !== 8'h00) begin fails++; $display("FAIL mid_async got %b want 0", rd_valid_cpu); end
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (rd_valid_cpu !== 8'h00) begin fails++; $display("FAIL mid_release got %b want 0", rd_valid_cpu); end
        tick();
        tests++; if (rd_valid_cpu !== 8'h00) begin fails++; $display("FAIL mid_release2 got %b want 0", rd_valid_cpu); end
        req_cpu    = 8'b0100_0010;
        adr_cpu[1] = 7'd32;
        adr_cpu[6] = 7'd33;
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h02) begin fails++; $display("FAIL mid_ptr0 got %b want 00000010", gnt_cpu); end
        tests++; if (adr_banki[1] !== 5'd0) begin fails++; $display("FAIL mid_ptr0_adr got %0d want 0", adr_banki[1]); end
        tick();
        req_cpu = 8'h40;
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h40) begin fails++; $display("FAIL mid_next_gnt got %b want 01000000", gnt_cpu); end
        tests++; if (rd_valid_cpu !== 8'h02) begin fails++; $display("FAIL mid_next_valid got %b want 00000010", rd_valid_cpu); end
        tick();
        req_cpu = '0;
        tests++; if (rd_cpu[6] !== mem_word(1, 1)) begin fails++; $display("FAIL mid_next_data got %h want %h", rd_cpu[6], mem_word(1, 1)); end
        tick();
    endtask

`ifdef XBAR_INTERLEAVE_EN
    task automatic test_interleave();
        req_cpu    = 8'h01;
        adr_cpu[0] = 7'd37;
        @(negedge clk);
        tests++; if (en_banki !== 3'b010) begin fails++; $display("FAIL il_en got %b want 010", en_banki); end
        tests++; if (adr_banki[1] !== 5'd12) begin fails++; $display("FAIL il_adr got %0d want 12", adr_banki[1]); end
        tick();
        req_cpu = '0;
        tests++; if (rd_cpu[0] !== mem_word(1, 12)) begin fails++; $display("FAIL il_data got %h want %h", rd_cpu[0], mem_word(1, 12)); end
        req_cpu    = 8'h07;
        adr_cpu[0] = 7'd0;
        adr_cpu[1] = 7'd1;
        adr_cpu[2] = 7'd2;
        @(negedge clk);
        tests++; if (gnt_cpu !== 8'h07) begin fails++; $display("FAIL il_gnt got %b want 00000111", gnt_cpu); end
        tests++; if (en_banki !== 3'b111) begin fails++; $display("FAIL il_en3 got %b want 111", en_banki); end
        tests++; if (adr_banki !== '0) begin fails++; $display("FAIL il_adr3 got %h want 0", adr_banki); end
        tick();
        req_cpu = '0;
        tick();
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        req_cpu = '0;
        adr_cpu = '0;
        test_reset();
`ifdef XBAR_INTERLEAVE_EN
        test_oor();
        test_interleave();
`else
        test_single();
        test_conflict();
        test_parallel();
        test_oor();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
